// File: rtl/commit_unit.sv
// In-order commit unit: allocates entries in program order, marks them done on
// out-of-order completion, retires one per cycle. Optional flush: COMMIT_UNIT_FLUSH_EN.
module commit_unit #(
  parameter int p_depth          = 16,
  parameter int p_phys_addr_bits = 6,
  parameter int p_seq_num_bits   = $clog2(p_depth)
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef COMMIT_UNIT_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        alloc_en,
  output logic                        alloc_rdy,
  input  logic [4:0]                  alloc_areg,
  input  logic [p_phys_addr_bits-1:0] alloc_preg,
  input  logic [p_phys_addr_bits-1:0] alloc_ppreg,
  output logic [p_seq_num_bits-1:0]   alloc_seq,
  input  logic                        complete_val,
  input  logic [p_seq_num_bits-1:0]   complete_seq,
  output logic                        commit_val,
  output logic [p_seq_num_bits-1:0]   commit_seq,
  output logic [4:0]                  commit_areg,
  output logic [p_phys_addr_bits-1:0] commit_preg,
  output logic [p_phys_addr_bits-1:0] commit_ppreg
);

  localparam int PTR_W = p_seq_num_bits + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
  logic [p_depth-1:0]          valid_q, valid_d, done_q, done_d;
  logic [4:0]                  areg_q  [p_depth];
  logic [4:0]                  areg_d  [p_depth];
  logic [p_phys_addr_bits-1:0] preg_q  [p_depth];
  logic [p_phys_addr_bits-1:0] preg_d  [p_depth];
  logic [p_phys_addr_bits-1:0] ppreg_q [p_depth];
  logic [p_phys_addr_bits-1:0] ppreg_d [p_depth];

  logic                        commit_val_q, commit_val_d;
  logic [p_seq_num_bits-1:0]   commit_seq_q, commit_seq_d;
  logic [4:0]                  commit_areg_q, commit_areg_d;
  logic [p_phys_addr_bits-1:0] commit_preg_q, commit_preg_d;
  logic [p_phys_addr_bits-1:0] commit_ppreg_q, commit_ppreg_d;

  logic [p_seq_num_bits-1:0] head_idx, tail_idx;
  logic empty, full, alloc_fire, commit_fire;

  assign head_idx    = head_q[p_seq_num_bits-1:0];
  assign tail_idx    = tail_q[p_seq_num_bits-1:0];
  assign empty       = (head_q == tail_q);
  assign full        = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);
  assign alloc_rdy   = !full;
  assign alloc_seq   = tail_idx;
  assign alloc_fire  = alloc_en && !full;
  assign commit_fire = !empty && valid_q[head_idx] && done_q[head_idx];

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    valid_d        = valid_q;
    done_d         = done_q;
    areg_d         = areg_q;
    preg_d         = preg_q;
    ppreg_d        = ppreg_q;
    commit_val_d   = 1'b0;
    commit_seq_d   = commit_seq_q;
    commit_areg_d  = commit_areg_q;
    commit_preg_d  = commit_preg_q;
    commit_ppreg_d = commit_ppreg_q;

    if (complete_val && valid_q[complete_seq])
      done_d[complete_seq] = 1'b1;

    // Commit decision uses pre-edge done, so a completion never retires in the same edge.
    if (commit_fire) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + PTR_ONE;
      commit_val_d      = 1'b1;
      commit_seq_d      = head_idx;
      commit_areg_d     = areg_q[head_idx];
      commit_preg_d     = preg_q[head_idx];
      commit_ppreg_d    = ppreg_q[head_idx];
    end

    // The tail slot is never valid, so it cannot collide with the completion above.
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      areg_d[tail_idx]  = alloc_areg;
      preg_d[tail_idx]  = alloc_preg;
      ppreg_d[tail_idx] = alloc_ppreg;
      tail_d            = tail_q + PTR_ONE;
    end

`ifdef COMMIT_UNIT_FLUSH_EN
    if (flush) begin
      head_d         = '0;
      tail_d         = '0;
      valid_d        = '0;
      done_d         = '0;
      commit_val_d   = 1'b0;
      commit_seq_d   = commit_seq_q;
      commit_areg_d  = commit_areg_q;
      commit_preg_d  = commit_preg_q;
      commit_ppreg_d = commit_ppreg_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      commit_val_q   <= 1'b0;
      commit_seq_q   <= '0;
      commit_areg_q  <= '0;
      commit_preg_q  <= '0;
      commit_ppreg_q <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      commit_val_q   <= commit_val_d;
      commit_seq_q   <= commit_seq_d;
      commit_areg_q  <= commit_areg_d;
      commit_preg_q  <= commit_preg_d;
      commit_ppreg_q <= commit_ppreg_d;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    areg_q  <= areg_d;
    preg_q  <= preg_d;
    ppreg_q <= ppreg_d;
  end

  assign commit_val   = commit_val_q;
  assign commit_seq   = commit_seq_q;
  assign commit_areg  = commit_areg_q;
  assign commit_preg  = commit_preg_q;
  assign commit_ppreg = commit_ppreg_q;

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: a queue-based program-order model predicts
// commits; a negedge monitor pops and compares every commit pulse.
module tb_commit_unit;
  localparam int DEPTH = 16;
  localparam int PB    = 6;
  localparam int SB    = 4;
  localparam int CW    = SB + 5 + 2 * PB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          alloc_en = 1'b0;
  logic          alloc_rdy;
  logic [4:0]    alloc_areg = '0;
  logic [PB-1:0] alloc_preg = '0;
  logic [PB-1:0] alloc_ppreg = '0;
  logic [SB-1:0] alloc_seq;
  logic          complete_val = 1'b0;
  logic [SB-1:0] complete_seq = '0;
  logic          commit_val;
  logic [SB-1:0] commit_seq;
  logic [4:0]    commit_areg;
  logic [PB-1:0] commit_preg;
  logic [PB-1:0] commit_ppreg;

  always #5 clk = ~clk;

  commit_unit #(.p_depth(DEPTH), .p_phys_addr_bits(PB), .p_seq_num_bits(SB)) dut (
    .clk(clk),
    .rst(rst),
`ifdef COMMIT_UNIT_FLUSH_EN
    .flush(flush),
`endif
    .alloc_en(alloc_en),
    .alloc_rdy(alloc_rdy),
    .alloc_areg(alloc_areg),
    .alloc_preg(alloc_preg),
    .alloc_ppreg(alloc_ppreg),
    .alloc_seq(alloc_seq),
    .complete_val(complete_val),
    .complete_seq(complete_seq),
    .commit_val(commit_val),
    .commit_seq(commit_seq),
    .commit_areg(commit_areg),
    .commit_preg(commit_preg),
    .commit_ppreg(commit_ppreg)
  );

  typedef struct packed {
    logic [SB-1:0] seq;
    logic [4:0]    areg;
    logic [PB-1:0] preg;
    logic [PB-1:0] ppreg;
    logic          done;
  } ent_t;

  ent_t          mq[$];        // in-flight instructions, oldest first
  logic [SB-1:0] mnext = '0;   // sequence number the next allocation receives
  logic [CW-1:0] expq[$];
  int            checks = 0;
  int            errors = 0;
  logic          mon_en = 1'b0;

  task automatic step();
    ent_t          e;
    logic          commit;
    logic          was_full;
    logic          have_pend;
    logic [CW-1:0] pend;
    have_pend = 1'b0;
    pend      = '0;
    checks++;
    if ({alloc_rdy, alloc_seq} !== {(mq.size() < DEPTH), mnext}) begin
      errors++;
      $display("FAIL alloc_hs got rdy=%0b seq=%0d exp rdy=%0b seq=%0d",
               alloc_rdy, alloc_seq, (mq.size() < DEPTH), mnext);
    end
    if (rst || flush) begin
      mq.delete();
      mnext = '0;
    end else begin
      was_full = (mq.size() == DEPTH);
      commit   = (mq.size() > 0) && mq[0].done;
      if (commit) begin
        e         = mq[0];
        pend      = {e.seq, e.areg, e.preg, e.ppreg};
        have_pend = 1'b1;
      end
      if (complete_val)
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].seq == complete_seq) begin
            e      = mq[i];
            e.done = 1'b1;
            mq[i]  = e;
          end
      if (commit) void'(mq.pop_front());
      if (alloc_en && !was_full) begin
        mq.push_back({mnext, alloc_areg, alloc_preg, alloc_ppreg, 1'b0});
        mnext = mnext + 1'b1;
      end
    end
    @(posedge clk);
    if (have_pend) expq.push_back(pend);
    #1;
  endtask

  task automatic cyc(input logic ae, input logic [4:0] ar, input logic [PB-1:0] pr,
                     input logic [PB-1:0] pp, input logic cv, input logic [SB-1:0] cs);
    alloc_en     = ae;
    alloc_areg   = ar;
    alloc_preg   = pr;
    alloc_ppreg  = pp;
    complete_val = cv;
    complete_seq = cs;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  task automatic alloc_rand(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 5'($urandom_range(0, 31)), PB'($urandom_range(0, 63)),
          PB'($urandom_range(0, 63)), 1'b0, '0);
  endtask

  initial begin : monitor
    logic [CW-1:0] exp_c;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (commit_val === 1'b1) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected got seq=%0d ppreg=%0d exp no commit",
                     commit_seq, commit_ppreg);
          end else begin
            exp_c = expq.pop_front();
            if ({commit_seq, commit_areg, commit_preg, commit_ppreg} !== exp_c) begin
              errors++;
              $display("FAIL commit_data got %h exp %h",
                       {commit_seq, commit_areg, commit_preg, commit_ppreg}, exp_c);
            end
          end
        end else if (expq.size() > 0) begin
          checks++;
          errors++;
          exp_c = expq.pop_front();
          $display("FAIL commit_missing got commit_val=%b exp commit %h", commit_val, exp_c);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    idle(1);
    rst = 1'b0;
    mon_en = 1'b1;
    checks++;
    if (commit_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_commit_val got %b exp 0", commit_val);
    end
    checks++;
    if ({commit_seq, commit_areg, commit_preg, commit_ppreg} !== '0) begin
      errors++;
      $display("FAIL reset_commit_data got %h exp 0",
               {commit_seq, commit_areg, commit_preg, commit_ppreg});
    end

    // three allocations, completed youngest first
    cyc(1'b1, 5'd1, 6'd32, 6'd1, 1'b0, '0);
    cyc(1'b1, 5'd2, 6'd33, 6'd2, 1'b0, '0);
    cyc(1'b1, 5'd3, 6'd34, 6'd3, 1'b0, '0);
    idle(2);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd2);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd1);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd0);
    idle(5);

    // fill to full, push against full, then free one slot and wrap
    do_reset();
    alloc_rand(DEPTH);
    cyc(1'b1, 5'd7, 6'd7, 6'd7, 1'b1, 4'd0);
    cyc(1'b1, 5'd8, 6'd8, 6'd8, 1'b0, '0);
    cyc(1'b1, 5'd9, 6'd9, 6'd9, 1'b0, '0);
    cyc(1'b1, 5'd10, 6'd10, 6'd10, 1'b0, '0);
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, '0, '0, '0, 1'b1, SB'(k));
    idle(DEPTH + 4);

    // completion to an invalid entry is dropped
    do_reset();
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd5);
    alloc_rand(6);
    idle(4);
    for (int k = 0; k < 6; k++) cyc(1'b0, '0, '0, '0, 1'b1, SB'(k));
    idle(8);

    // reset with done entries pending behind a not-done head
    do_reset();
    alloc_rand(5);
    for (int k = 1; k < 5; k++) cyc(1'b0, '0, '0, '0, 1'b1, SB'(k));
    do_reset();
    idle(4);

`ifdef COMMIT_UNIT_FLUSH_EN
    alloc_rand(5);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd3);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd4);
    flush = 1'b1;
    cyc(1'b1, 5'd4, 6'd4, 6'd4, 1'b1, 4'd0);
    flush = 1'b0;
    idle(4);
    alloc_rand(1);
    do_reset();
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      cyc(1'b1 & ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)),
          PB'($urandom_range(0, 63)), PB'($urandom_range(0, 63)),
          ($urandom_range(0, 9) < 7), SB'($urandom_range(0, DEPTH - 1)));
      rst = 1'b0;
    end

    // drain everything still in flight
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, '0, '0, '0, 1'b1, SB'(k));
    idle(DEPTH + 4);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding exp 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
# commit_unit

In-order commit unit (reorder buffer) for the decode/issue back end. It allocates one entry per renamed instruction in program order and accepts out-of-order completion notifications from writeback. Completed entries retire in order, one per cycle, and the block publishes a commit notification carrying `preg`/`ppreg`. This is the publisher side of the commit-notification channel that the rename table and free list subscribe to.

## Interface
Parameters:
- `p_depth`, 16, number of entries; power of two, ≥ 2
- `p_phys_addr_bits`, 6, physical register address width
- `p_seq_num_bits`, `$clog2(p_depth)`, sequence-number (entry index) width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `alloc_en`  in  1  request an entry this cycle
- `alloc_rdy`  out  1  entry available; transfer occurs when `alloc_en & alloc_rdy`
- `alloc_areg`  in  5  architectural destination register
- `alloc_preg`  in  `p_phys_addr_bits`  newly allocated physical register
- `alloc_ppreg`  in  `p_phys_addr_bits`  previous mapping of `alloc_areg`
- `alloc_seq`  out  `p_seq_num_bits`  entry index granted; valid while `alloc_rdy`
- `complete_val`  in  1  an instruction finished writeback
- `complete_seq`  in  `p_seq_num_bits`  index of the finished entry
- `commit_val`  out  1  commit notification valid; one-cycle pulse per retired entry
- `commit_seq`  out  `p_seq_num_bits`  retired entry index
- `commit_areg`  out  5  retired architectural register
- `commit_preg`  out  `p_phys_addr_bits`  retired physical register
- `commit_ppreg`  out  `p_phys_addr_bits`  physical register to free

## Operation
- Storage: circular array of `p_depth` entries. Each entry holds `{valid, done, areg, preg, ppreg}`.
- Pointers:
  - `head` and `tail` are `p_seq_num_bits+1` bits wide; the MSB is a wrap bit.
  - Empty when `head == tail`.
  - Full when the index bits are equal and the wrap bits differ.
- Allocate:
  - `alloc_rdy = !full`; `alloc_seq = tail[idx]`.
  - On transfer, write the entry with `valid=1, done=0`, then increment `tail`. Index wraps from `p_depth-1` to 0 and the wrap bit toggles.
- Complete:
  - If `complete_val` and `entry[complete_seq].valid`, set `done=1`.
  - Completion to an invalid entry is ignored.
  - Repeated completion of the same entry is idempotent.
- Commit:
  - At each edge, if `!empty`, the head entry is valid, and its `done` is set: clear `valid`, increment `head`, and register that entry's fields onto the `commit_*` outputs with `commit_val=1`.
  - Otherwise `commit_val=0` and the `commit_*` data outputs hold their previous values.
  - At most one commit per cycle.
- `areg == 0` entries commit normally. The subscriber ignores `ppreg == 0`.

## Timing
- Reset values:
  - `head = tail = 0`; all `valid = done = 0`.
  - `commit_val=0`; `commit_seq=0`, `commit_areg=0`, `commit_preg=0`, `commit_ppreg=0`.
  - `alloc_rdy=1`, `alloc_seq=0`.
- Reset mid-operation discards all entries with no commit pulses.
- `alloc_rdy` and `alloc_seq` are combinational from state only. They do not depend on `alloc_en`.
- Completion sampled at edge E sets `done` at E. The earliest commit of that entry is at edge E+1, so `commit_val` is high in the cycle following E+1. There is no completion-to-commit bypass.
- Full with a commit at the same edge: `alloc_rdy` stays 0 that cycle; the freed slot is visible next cycle. No bypass.
- Allocate and commit at the same edge are both permitted; the count is unchanged.
- Complete and allocate targeting the same index in the same cycle cannot occur, because an allocated index is never valid. A completion for a not-yet-valid index is ignored.
- Back-to-back done entries commit at one per cycle, consecutive pulses.

## Configuration
- `COMMIT_UNIT_FLUSH_EN` defined:
  - Adds input port `flush` (1 bit).
  - `flush` at an edge clears all `valid`/`done` and sets `head = tail = 0`.
  - `commit_val` is 0 in the following cycle.
  - Priority: `rst` > `flush` > commit/allocate/complete; all other events in the same cycle are dropped.
- Not defined: no `flush` port. Entries are only removed by commit or `rst`.

## Test plan
- Reset, then allocate 3 entries (`areg` 1/2/3, `preg` 32/33/34, `ppreg` 1/2/3) → `alloc_seq` 0, 1, 2; `commit_val` stays 0.
- Complete seq 2, then 1, then 0 on consecutive cycles → commits in order seq 0, 1, 2 in three consecutive cycles. The first `commit_val` appears one cycle after seq 0 completes; `commit_ppreg` is 1, 2, 3.
- Allocate 16 entries with `p_depth=16` → `alloc_rdy=0`. Complete seq 0 → one commit; `alloc_rdy=1` the cycle after the commit edge, and the next allocation wraps to `alloc_seq=0`.
- `complete_val` with `complete_seq=5` while entry 5 is invalid → no state change. A later allocate of index 5 has `done=0` and does not commit until completed.
- Assert `rst` while 4 done entries are pending → no `commit_val` after reset; `alloc_seq=0`, `alloc_rdy=1`.
- With `COMMIT_UNIT_FLUSH_EN`: 5 entries allocated, 2 done, `flush` pulsed → no commits afterward; next `alloc_seq=0`.
